// File: rtl/dp_ram_be.sv
// dp_ram_be: true dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write, optional output register and power-up clear.
//
// Ports (x = a | b, both ports identical):
//   clk, rst_n     rising-edge clock, async active-low reset
//   en_x, we_x     access request / write qualifier
//   be_x [NB]      byte-lane write enables
//   addr_x, data_x address and write data
//   q_x, valid_x   read word and its update strobe
//   busy           clear sequence running, requests dropped
//   collision      same-address cross-port access with a write

module dp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_a,
  input  logic                             we_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            data_a,
  output logic [DATA_WIDTH-1:0]            q_a,
  output logic                             valid_a,
  input  logic                             en_b,
  input  logic                             we_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            data_b,
  output logic [DATA_WIDTH-1:0]            q_b,
  output logic                             valid_b,
  output logic                             busy,
  output logic                             collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nx;
  logic                  clr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic acc_a;
  logic acc_b;
  logic wr_a;
  logic wr_b;

  logic [DATA_WIDTH-1:0] old_a;
  logic [DATA_WIDTH-1:0] old_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        r[i*BYTE_WIDTH +: BYTE_WIDTH] =
          new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return r;
  endfunction

  // Clear sequencer

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr      = 1'b0;
    unique case (state)
      S_CLEAR: begin
        clr    = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == '1) begin
          state_nx = S_IDLE;
        end
      end
      S_IDLE: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign busy  = (state == S_CLEAR);
  assign acc_a = en_a & ~busy;
  assign acc_b = en_b & ~busy;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;

  // Array write. B is applied after A so that lanes enabled on
  // both ports at the same address end up holding B's data.

  always_ff @(posedge clk) begin
    if (clr) begin
      mem[cnt] <= '0;
    end else begin
      if (wr_a) begin
        for (int i = 0; i < NB; i++) begin
          if (be_a[i]) begin
            mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <=
              data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
      if (wr_b) begin
        for (int i = 0; i < NB; i++) begin
          if (be_b[i]) begin
            mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <=
              data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Read word. Only the port's own write is merged in (write-first);
  // a write from the other port is never visible in the same cycle.

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  always_comb begin
    rd_a = old_a;
    rd_b = old_b;
    if (RDW_MODE == 0) begin
      if (we_a) begin
        rd_a = merge(old_a, data_a, be_a);
      end
      if (we_b) begin
        rd_b = merge(old_b, data_b, be_b);
      end
    end
  end

  // Output stage(s)

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] d_a;
    logic [DATA_WIDTH-1:0] d_b;
    logic                  v_a;
    logic                  v_b;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_a     <= '0;
        d_b     <= '0;
        v_a     <= 1'b0;
        v_b     <= 1'b0;
        q_a     <= '0;
        q_b     <= '0;
        valid_a <= 1'b0;
        valid_b <= 1'b0;
      end else begin
        v_a     <= acc_a;
        v_b     <= acc_b;
        valid_a <= v_a;
        valid_b <= v_b;
        if (acc_a) d_a <= rd_a;
        if (acc_b) d_b <= rd_b;
        if (v_a)   q_a <= d_a;
        if (v_b)   q_b <= d_b;
      end
    end
  end else begin : g_noreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_a     <= '0;
        q_b     <= '0;
        valid_a <= 1'b0;
        valid_b <= 1'b0;
      end else begin
        valid_a <= acc_a;
        valid_b <= acc_b;
        if (acc_a) q_a <= rd_a;
        if (acc_b) q_b <= rd_b;
      end
    end
  end

  // Collision flag is always one cycle after acceptance.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else begin
      collision <= acc_a & acc_b &
                   (addr_a == addr_b) &
                   (we_a | we_b);
    end
  end

endmodule

// File: tb/tb_dp_ram_be.sv
// tb_dp_ram_be: scoreboard bench for dp_ram_be, three parameter sets
// (write-first, read-first, write-first with output register).

module tb_dp_ram_be;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int ND = 3;
  localparam int OREG [ND] = '{0, 0, 1};
  localparam int RDWM [ND] = '{0, 1, 0};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  logic          en_a = 0, we_a = 0, en_b = 0, we_b = 0;
  logic [3:0]    be_a = 0, be_b = 0;
  logic [AW-1:0] addr_a = 0, addr_b = 0;
  logic [DW-1:0] data_a = 0, data_b = 0;

  logic [DW-1:0] q_a [ND];
  logic [DW-1:0] q_b [ND];
  logic          valid_a [ND];
  logic          valid_b [ND];
  logic          busy [ND];
  logic          collision [ND];

  dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .data_a(data_a), .q_a(q_a[0]), .valid_a(valid_a[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .data_b(data_b), .q_b(q_b[0]), .valid_b(valid_b[0]),
    .busy(busy[0]), .collision(collision[0]));

  dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .RDW_MODE(1), .OUT_REG(0), .INIT_CLEAR(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .data_a(data_a), .q_a(q_a[1]), .valid_a(valid_a[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .data_b(data_b), .q_b(q_b[1]), .valid_b(valid_b[1]),
    .busy(busy[1]), .collision(collision[1]));

  dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .RDW_MODE(0), .OUT_REG(1), .INIT_CLEAR(1)) u2 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .data_a(data_a), .q_a(q_a[2]), .valid_a(valid_a[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .data_b(data_b), .q_b(q_b[2]), .valid_b(valid_b[2]),
    .busy(busy[2]), .collision(collision[2]));

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t          sb [2*ND][$];
  logic [DW-1:0] lastq [2*ND];
  logic [DW-1:0] mem_m [2**AW];
  int            cyc;
  int            clr_left;
  int            n_chk;
  int            n_pass;

  function automatic logic [DW-1:0] lane_merge(
    input logic [DW-1:0] o,
    input logic [DW-1:0] n,
    input logic [3:0]    be
  );
    logic [DW-1:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h expected %h (cycle %0d)",
             tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs(input logic coll);
    logic          expv;
    logic          v;
    logic [DW-1:0] q;
    int            i;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("dut%0d busy", k), 32'(busy[k]),
          32'(clr_left > 0));
      chk($sformatf("dut%0d collision", k), 32'(collision[k]),
          32'(coll));
      for (int p = 0; p < 2; p++) begin
        i    = 2 * k + p;
        expv = (sb[i].size() > 0) && (sb[i][0].due == cyc);
        if (expv) lastq[i] = sb[i].pop_front().d;
        v = p ? valid_b[k] : valid_a[k];
        q = p ? q_b[k] : q_a[k];
        chk($sformatf("dut%0d valid_%s", k, p ? "b" : "a"),
            32'(v), 32'(expv));
        chk($sformatf("dut%0d q_%s", k, p ? "b" : "a"), q, lastq[i]);
      end
    end
  endtask

  task automatic step(
    input logic ea, input logic wa, input logic [3:0] ba,
    input logic [AW-1:0] aa, input logic [DW-1:0] da,
    input logic eb, input logic wb, input logic [3:0] bb,
    input logic [AW-1:0] ab, input logic [DW-1:0] db
  );
    logic          acc_a;
    logic          acc_b;
    logic          coll;
    logic [DW-1:0] old_a;
    logic [DW-1:0] old_b;
    exp_t          e;
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_b = db;
    acc_a = ea && (clr_left == 0);
    acc_b = eb && (clr_left == 0);
    old_a = mem_m[aa];
    old_b = mem_m[ab];
    for (int k = 0; k < ND; k++) begin
      e.due = cyc + 1 + OREG[k];
      if (acc_a) begin
        e.d = (wa && RDWM[k] == 0) ? lane_merge(old_a, da, ba) : old_a;
        sb[2*k].push_back(e);
      end
      if (acc_b) begin
        e.d = (wb && RDWM[k] == 0) ? lane_merge(old_b, db, bb) : old_b;
        sb[2*k+1].push_back(e);
      end
    end
    coll = acc_a && acc_b && (aa == ab) && (wa || wb);
    if (acc_a && wa) mem_m[aa] = lane_merge(mem_m[aa], da, ba);
    if (acc_b && wb) mem_m[ab] = lane_merge(mem_m[ab], db, bb);
    @(posedge clk);
    #1;
    cyc++;
    if (clr_left > 0) clr_left--;
    check_outputs(coll);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] be);
    step(1, 1, be, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("dut%0d rst q_a", k), q_a[k], 0);
      chk($sformatf("dut%0d rst q_b", k), q_b[k], 0);
      chk($sformatf("dut%0d rst valid_a", k), 32'(valid_a[k]), 0);
      chk($sformatf("dut%0d rst valid_b", k), 32'(valid_b[k]), 0);
      chk($sformatf("dut%0d rst collision", k), 32'(collision[k]), 0);
      chk($sformatf("dut%0d rst busy", k), 32'(busy[k]), 1);
    end
    for (int i = 0; i < 2 * ND; i++) begin
      sb[i].delete();
      lastq[i] = '0;
    end
    for (int a = 0; a < 2 ** AW; a++) mem_m[a] = '0;
    clr_left = 2 ** AW;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    cyc    = 0;
    n_chk  = 0;
    n_pass = 0;
    #2;
    do_reset();

    // Clear period: a write issued mid-clear must be dropped
    for (int i = 0; i < 16; i++) begin
      if (i == 4) wr_a(2, 32'h5555_5555, 4'hf);
      else idle(1);
    end
    for (int a = 0; a < 16; a++) begin
      step(1, 0, 0, 4'(a), 0, 1, 0, 0, 4'(15 - a), 0);
    end
    idle(2);

    // Byte-lane merge and read-during-write
    wr_a(3, 32'hAABB_CCDD, 4'b1111);
    wr_a(3, 32'h1122_3344, 4'b0101);
    step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    wr_a(3, 32'hFFFF_FFFF, 4'b0000);
    step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Back-to-back reads on port B
    wr_a(7, 32'h7070_7070, 4'hf);
    step(1, 1, 4'hf, 8, 32'h8080_8080, 1, 1, 4'hf, 9, 32'h9090_9090);
    step(0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 9, 0);
    idle(3);

    // Write/write collision, then read/read (legal, no flag)
    step(1, 1, 4'b1111, 5, 32'h1234_5678,
         1, 1, 4'b0011, 5, 32'hFFFF_FFFF);
    idle(1);
    step(1, 0, 0, 5, 0, 1, 0, 0, 5, 0);
    idle(2);

    // Read/write collision
    wr_a(9, 32'hCAFE_0001, 4'hf);
    step(1, 0, 0, 9, 0, 1, 1, 4'hf, 9, 32'hDEAD_0002);
    idle(1);
    step(1, 0, 0, 9, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Reset with live data, then reset again mid-clear
    do_reset();
    idle(10);
    do_reset();
    idle(16);
    step(1, 0, 0, 3, 0, 1, 0, 0, 9, 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
